// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad (Basys3 Pmod layout), debounces whole scans and
//   reports each newly accepted key as a hex code with a one-clock strobe.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   keypad column drive, active-low, one bit low at a time
//   key_code   hex code of the last accepted key
//   key_valid  one-clock pulse when a new key is accepted
//   key_held   high while an accepted key remains pressed
//
// Parameters
//   SCAN_DIV        clocks per column dwell (>= 4)
//   DEBOUNCE_SCANS  consecutive identical full scans needed to accept (>= 1)
module keypad_scanner #(
    parameter int SCAN_DIV       = 250000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE_SCANS);
    localparam logic [STB_W-1:0] STB_ONE = STB_W'(1);

    typedef enum logic {IDLE, PRESSED} state_t;

    // Label of key at (row r, column c).
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    logic [3:0]       row_meta_q, row_meta_d, row_sync_q, row_sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       col_q, col_d;
    logic             acc_hit_q, acc_hit_d;
    logic [3:0]       acc_code_q, acc_code_d;
    logic             cand_hit_q, cand_hit_d;
    logic [3:0]       cand_code_q, cand_code_d;
    logic [STB_W-1:0] stable_q, stable_d;
    state_t           state_q, state_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic       tick, eos, qualified, same;
    logic       col_hit;
    logic [1:0] col_row;
    logic       samp_hit;
    logic [3:0] samp_code;

    always_comb begin
        row_meta_d = row;
        row_sync_d = row_meta_q;

        tick = (cnt_q == CNT_MAX);
        eos  = tick && (idx_q == 2'd3);

        // Lowest pressed row in the currently driven column.
        col_hit = ~&row_sync_q;
        if (!row_sync_q[0])      col_row = 2'd0;
        else if (!row_sync_q[1]) col_row = 2'd1;
        else if (!row_sync_q[2]) col_row = 2'd2;
        else                     col_row = 2'd3;

        // Scan result including this dwell's sample; an earlier column wins.
        samp_hit  = acc_hit_q;
        samp_code = acc_code_q;
        if (tick && !acc_hit_q && col_hit) begin
            samp_hit  = 1'b1;
            samp_code = key_map(col_row, idx_q);
        end

        // Code stays 0 for "no key", so a plain compare covers the none case.
        same = (samp_hit == cand_hit_q) && (samp_code == cand_code_q);

        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        col_d       = col_q;
        acc_hit_d   = acc_hit_q;
        acc_code_d  = acc_code_q;
        cand_hit_d  = cand_hit_q;
        cand_code_d = cand_code_q;
        stable_d    = stable_q;
        qualified   = 1'b0;

        if (tick) begin
            cnt_d      = '0;
            idx_d      = idx_q + 2'd1;
            col_d      = ~(4'b0001 << idx_d);
            acc_hit_d  = samp_hit;
            acc_code_d = samp_code;
            if (eos) begin
                acc_hit_d  = 1'b0;
                acc_code_d = 4'h0;
                if (same) begin
                    if (stable_q != STB_MAX) stable_d = stable_q + STB_ONE;
                end else begin
                    cand_hit_d  = samp_hit;
                    cand_code_d = samp_code;
                    stable_d    = STB_ONE;
                end
                // Only the transition into the full count qualifies; a
                // differing scan with DEBOUNCE_SCANS = 1 qualifies at once.
                qualified = (stable_d == STB_MAX) && (!same || stable_q != STB_MAX);
            end
        end

        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (qualified) begin
            case (state_q)
                IDLE: begin
                    if (cand_hit_d) begin
                        key_code_d  = cand_code_d;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        state_d     = PRESSED;
                    end
                end
                default: begin
                    if (!cand_hit_d) begin
                        key_held_d = 1'b0;
                        state_d    = IDLE;
                    end else if (cand_code_d != key_code_q) begin
                        // Rollover onto a different key.
                        key_code_d  = cand_code_d;
                        key_valid_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q  <= 4'b1111;
            row_sync_q  <= 4'b1111;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            col_q       <= 4'b1110;
            acc_hit_q   <= 1'b0;
            acc_code_q  <= 4'h0;
            cand_hit_q  <= 1'b0;
            cand_code_q <= 4'h0;
            stable_q    <= '0;
            state_q     <= IDLE;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            col_q       <= col_d;
            acc_hit_q   <= acc_hit_d;
            acc_code_q  <= acc_code_d;
            cand_hit_q  <= cand_hit_d;
            cand_code_q <= cand_code_d;
            stable_q    <= stable_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A small keypad model pulls row[r] low while col[c] is low for each key
// (r,c) set in the keys mask (bit r*4+c). A full scan is 16 clocks, so a key
// pressed right after a scan end is accepted 48 clocks later.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [15:0] keys = 16'h0000;

    int errors = 0;
    int checks = 0;

    // Monitor state, restarted by clr_mon().
    int         step_n;
    int         pulses;
    int         pulse_step;
    int         pulse_code;
    int         fall_step;
    int         rises;
    int         doubles = 0;
    logic       prev_valid = 1'b0;
    logic       prev_held  = 1'b0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic clr_mon();
        step_n     = 0;
        pulses     = 0;
        pulse_step = -1;
        pulse_code = -1;
        fall_step  = -1;
        rises      = 0;
    endtask

    // Advance n clocks, sampling outputs on the falling edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step_n++;
            if (key_valid) begin
                pulses++;
                pulse_step = step_n;
                pulse_code = int'(key_code);
                if (prev_valid) doubles++;
            end
            if (prev_held && !key_held && fall_step < 0) fall_step = step_n;
            if (!prev_held && key_held) rises++;
            prev_valid = key_valid;
            prev_held  = key_held;
        end
    endtask

    initial begin
        // 1: reset state and column walk
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr_mon();
        chk("rst_col", int'(col), 4'b1110);
        chk("rst_code", int'(key_code), 0);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_held", int'(key_held), 0);
        run(4);
        chk("walk_col1", int'(col), 4'b1101);
        run(4);
        chk("walk_col2", int'(col), 4'b1011);
        run(4);
        chk("walk_col3", int'(col), 4'b0111);
        chk("walk_pulses", pulses, 0);
        chk("walk_held", int'(key_held), 0);
        chk("walk_code", int'(key_code), 0);
        run(4);
        chk("walk_wrap", int'(col), 4'b1110);

        // 2: key 5 held steadily
        keys = 16'h0020;
        clr_mon();
        run(48);
        chk("k5_pulses", pulses, 1);
        chk("k5_step", pulse_step, 48);
        chk("k5_pcode", pulse_code, 5);
        chk("k5_held", int'(key_held), 1);
        clr_mon();
        run(160);
        chk("k5_norepeat", pulses, 0);
        chk("k5_held_still", int'(key_held), 1);
        chk("k5_code_still", int'(key_code), 5);

        // 4: release
        keys = 16'h0000;
        clr_mon();
        run(48);
        chk("rel_fall_step", fall_step, 48);
        chk("rel_pulses", pulses, 0);
        chk("rel_code", int'(key_code), 5);
        chk("rel_held", int'(key_held), 0);

        // 3: bounce, toggling every 2 scans
        clr_mon();
        for (int i = 0; i < 3; i++) begin
            keys = 16'h0020;
            run(32);
            keys = 16'h0000;
            run(32);
        end
        chk("bnc_pulses", pulses, 0);
        chk("bnc_rises", rises, 0);
        chk("bnc_held", int'(key_held), 0);

        // 5: keys 1 and D together, then release 1
        keys = 16'h8001;
        clr_mon();
        run(48);
        chk("multi_pulses", pulses, 1);
        chk("multi_step", pulse_step, 48);
        chk("multi_code", pulse_code, 1);
        keys = 16'h8000;
        clr_mon();
        run(48);
        chk("roll_pulses", pulses, 1);
        chk("roll_step", pulse_step, 48);
        chk("roll_code", pulse_code, 4'hD);
        chk("roll_fall", fall_step, -1);
        chk("roll_held", int'(key_held), 1);

        // 6: roll to key 5, then reset while held
        keys = 16'h0020;
        clr_mon();
        run(48);
        chk("k5b_code", pulse_code, 5);
        rst = 1'b1;
        run(1);
        chk("mid_rst_col", int'(col), 4'b1110);
        chk("mid_rst_code", int'(key_code), 0);
        chk("mid_rst_valid", int'(key_valid), 0);
        chk("mid_rst_held", int'(key_held), 0);
        rst = 1'b0;
        clr_mon();
        run(48);
        chk("post_rst_pulses", pulses, 1);
        chk("post_rst_step", pulse_step, 48);
        chk("post_rst_code", pulse_code, 5);
        chk("post_rst_held", int'(key_held), 1);

        chk("no_double_valid", doubles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
